// File: rtl/lane_pkg.sv
// Lane-level definitions shared by the serializer and deserializer.
// The state encodings must match the transmit side.
package lane_pkg;

    localparam logic [1:0] DISCONNECTED_S = 2'h0;
    localparam logic [1:0] IDLE_S         = 2'h1;
    localparam logic [1:0] START          = 2'h2;
    localparam logic [1:0] RESERVED_S     = 2'h3;

    localparam int LANE_SYM_W = 10;

    function automatic logic is_start(input logic [1:0] st);
        return st == START;
    endfunction

endpackage

// File: rtl/deserializer_run_length_detector.sv
// Counts consecutive serial bits equal to TARGET and raises det once LEN are seen.
// The counter saturates at LEN, so det stays high for as long as the run lasts.
module run_length_detector #(
    parameter int LEN    = 16,
    parameter bit TARGET = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic ser_in,
    output logic det
);

    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LEN_C = CW'(LEN);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          det_q, det_d;

    always_comb begin
        cnt_d = '0;
        if (ser_in == TARGET)
            cnt_d = (cnt_q == LEN_C) ? cnt_q : cnt_q + 1'b1;
        // Flag is registered from the next count, so it rises with the LEN-th bit.
        det_d = (cnt_d == LEN_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            det_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            det_q <= det_d;
        end
    end

    assign det = det_q;

endmodule

// File: rtl/deserializer.sv
// Receive-side lane deserializer: LSB-first bit stream to DATA_WIDTH-bit symbols,
// plus idle (all ones) and disconnect (all zeros) run-length detection.
module deserializer
    import lane_pkg::*;
#(
    parameter int DATA_WIDTH   = LANE_SYM_W,
    parameter int IDLE_DET_LEN = 16,
    parameter int DISC_DET_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            rx_state,
    input  logic                  ser_in,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  data_valid,
    output logic                  frame_abort,
    output logic                  idle_det,
    output logic                  disc_det
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pout_q, pout_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  valid_q, valid_d;
    logic                  abort_q, abort_d;

    always_comb begin
        shift_d   = shift_q;
        pout_d    = pout_q;
        bit_cnt_d = '0;
        valid_d   = 1'b0;
        abort_d   = 1'b0;
        if (is_start(rx_state)) begin
            shift_d = {ser_in, shift_q[DATA_WIDTH-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
                pout_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else begin
            // bit_cnt is only nonzero outside START on the first cycle after leaving it.
            abort_d = (bit_cnt_q != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            pout_q    <= '0;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            pout_q    <= pout_d;
            bit_cnt_q <= bit_cnt_d;
            valid_q   <= valid_d;
            abort_q   <= abort_d;
        end
    end

    assign parallel_out = pout_q;
    assign data_valid   = valid_q;
    assign frame_abort  = abort_q;

    run_length_detector #(.LEN(IDLE_DET_LEN), .TARGET(1'b1)) u_idle_det (
        .clk    (clk),
        .rst    (rst),
        .ser_in (ser_in),
        .det    (idle_det)
    );

    run_length_detector #(.LEN(DISC_DET_LEN), .TARGET(1'b0)) u_disc_det (
        .clk    (clk),
        .rst    (rst),
        .ser_in (ser_in),
        .det    (disc_det)
    );

endmodule
